ap_ctrl_chain_driver: RTL and testbench
=======================================

// Module: ap_ctrl_chain_driver
// PURPOSE
//  Synthesizable initiator for the HLS ap_ctrl_chain block protocol: drives ap_start/ap_continue into a
//  kernel (e.g. hls_multiplier) for a programmed number of transactions and observes ap_ready/ap_done.
//  It keeps up to MAX_OUTSTANDING transactions in flight, adds programmable ap_continue back-pressure,
//  and reports started/done counts plus per-transaction latency. Sits between testbench/CPU config and the kernel.
// PARAMETERS
//  MAX_OUTSTANDING  2   max transactions accepted (ap_ready) but not yet completed (ap_done&ap_continue); 1..8
//  CNT_W            32  width of transaction counters and of cfg_num_txn
//  LAT_W            16  width of latency outputs; values saturate at 2**LAT_W-1
// PORTS
//  clock            in   1      single clock, all logic rising-edge
//  reset_n          in   1      asynchronous, active-low reset
//  cfg_start        in   1      one-cycle pulse: latch config, begin a run (ignored while busy)
//  cfg_num_txn      in   CNT_W  transactions to issue in this run
//  cfg_cont_delay   in   8      cycles ap_continue is withheld after ap_done first rises
//  ap_start         out  1      kernel start request
//  ap_ready         in   1      kernel accepted the start (handshake = ap_start & ap_ready)
//  ap_done          in   1      kernel result valid; held high until ap_continue
//  ap_continue      out  1      completion acknowledge (handshake = ap_done & ap_continue)
//  busy             out  1      run in progress
//  all_done         out  1      one-cycle pulse when the last completion is acknowledged
//  txn_started      out  CNT_W  start handshakes this run
//  txn_done         out  CNT_W  done handshakes this run
//  last_latency     out  LAT_W  cycles from start handshake to done handshake, most recent txn
//  max_latency      out  LAT_W  maximum last_latency this run
//  err_done         out  1      sticky: ap_done seen with zero outstanding; cleared by accepted cfg_start
// BEHAVIOUR
//  - Reset: all outputs 0; state S_IDLE; counters, timestamp FIFO and cycle counter cleared.
//  - FSM: S_IDLE -cfg_start-> S_ISSUE (or S_FINISH if cfg_num_txn==0); S_ISSUE -txn_started==num-> S_DRAIN;
//    S_DRAIN -txn_done==num-> S_FINISH; S_FINISH (1 cycle, all_done=1, busy=0) -> S_IDLE. busy=1 in ISSUE/DRAIN.
//  - cfg_start accepted only in S_IDLE: latches num/delay, clears counters, max_latency, err_done.
//  - ap_start registered; asserted when in S_ISSUE, txn_started<num, outstanding<MAX_OUTSTANDING. Once high it
//    stays high until handshake (never dropped early). On handshake cycle the next value re-evaluates with
//    updated counts, so back-to-back starts are possible (ap_start held high across consecutive ready cycles).
//  - outstanding = txn_started - txn_done; start and done handshakes in the same cycle leave it unchanged.
//  - Free-running 32-bit cycle counter; its value is pushed to the timestamp FIFO on each start handshake and
//    popped on each done handshake (push+pop same cycle legal, incl. when FIFO full). FIFO never overflows by
//    construction of the ap_start gating.
//  - Latency = done_cycle - pop_timestamp (mod 2**32), saturated to LAT_W; updates last/max on the cycle after
//    the done handshake.
//  - ap_continue: registered; a down-counter loads cfg_cont_delay on the first cycle ap_done is high; when it
//    reads 0 with ap_done high, ap_continue rises next cycle; drops the cycle after the handshake.
//    delay 0 -> ap_continue 1 cycle after ap_done rises. ap_continue never high while ap_done low.
//  - ap_done high with outstanding==0: err_done set, no handshake issued, counters untouched.
//  - Reset mid-run: immediate abort to reset state; no all_done pulse.
//  - Counters do not wrap within a run (num < 2**CNT_W).
// STRUCTURE
//  - Package ap_ctrl_pkg: state_e {S_IDLE,S_ISSUE,S_DRAIN,S_FINISH}, TS_W=32, sat_lat() function.
//  - Sub-module ap_ts_fifo (DEPTH=MAX_OUTSTANDING, WIDTH=TS_W): sync FIFO, simultaneous push/pop, async reset_n.
//  - Top holds FSM, counters, continue delay counter, latency/stats registers.
// TESTING
//  1 num=1, delay=0, kernel ready immediately, done 5 cycles later -> one start hs, ap_continue 1 cycle after
//    ap_done, last_latency=max_latency=5 (+handshake offset), all_done single pulse, busy 0 after.
//  2 num=4, MAX=2, ready always 1, done delayed 10 cycles -> outstanding never >2, ap_start low while 2
//    in flight, txn_started=txn_done=4, FIFO order preserved (latencies match per-txn).
//  3 num=3, delay=7 -> ap_done held 8 cycles before ap_continue each time; ap_start blocks when 2 outstanding.
//  4 num=0 -> all_done pulse 2 cycles after cfg_start, ap_start never asserted; cfg_start during busy ignored.
//  5 ap_done forced high in S_IDLE -> err_done=1, ap_continue stays 0; next cfg_start clears err_done.
//  6 reset_n asserted with 2 txns outstanding mid-run -> all outputs 0 asynchronously, no all_done; new run ok.

Source files
------------

// File: rtl/ap_ctrl_pkg.sv
// Shared types, widths and helpers for the ap_ctrl_chain initiator.
package ap_ctrl_pkg;

   localparam int unsigned TS_W  = 32;
   localparam int unsigned DLY_W = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_e;

   // Clamp a timestamp difference to the largest value representable in w bits.
   function automatic logic [TS_W-1:0] sat_lat(input logic [TS_W-1:0] v, input int unsigned w);
      logic [TS_W-1:0] lim;
      lim = (w >= TS_W) ? '1 : ((TS_W'(1) << w) - TS_W'(1));
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO: one entry per in-flight transaction, push and pop may coincide.
module ap_ts_fifo
   import ap_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = TS_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
   endfunction

   // Depth equals the issue limit, so the writer never catches the reader.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain initiator: issues a programmed number of kernel starts, acknowledges
// completions with programmable back-pressure, and reports counts and latencies.
module ap_ctrl_chain_driver
   import ap_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 32,
   parameter int unsigned LAT_W           = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_num_txn,
   input  logic [DLY_W-1:0] cfg_cont_delay,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             all_done,
   output logic [CNT_W-1:0] txn_started,
   output logic [CNT_W-1:0] txn_done,
   output logic [LAT_W-1:0] last_latency,
   output logic [LAT_W-1:0] max_latency,
   output logic             err_done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] started_q, started_d;
   logic [CNT_W-1:0] done_q, done_d;
   logic [DLY_W-1:0] delay_q, delay_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             ap_start_q, ap_start_d;
   logic             ap_continue_q, ap_continue_d;
   logic             busy_q, busy_d;
   logic             all_done_q, all_done_d;
   logic             err_q, err_d;
   logic [LAT_W-1:0] last_lat_q, last_lat_d;
   logic [LAT_W-1:0] max_lat_q, max_lat_d;
   logic [TS_W-1:0]  cyc_q;

   logic             start_hs;
   logic             done_hs;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [DLY_W-1:0] cur_cnt;
   logic [TS_W-1:0]  fifo_head;
   logic [LAT_W-1:0] lat_sat;

   assign outstanding = started_q - done_q;
   assign start_hs    = ap_start_q & ap_ready;
   // A done with nothing in flight is an error, never a handshake.
   assign done_hs     = ap_done & ap_continue_q & (outstanding != '0);
   assign lat_sat     = LAT_W'(sat_lat(cyc_q - fifo_head, LAT_W));

   ap_ts_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TS_W)
   ) u_ts_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (start_hs),
      .push_data_i (cyc_q),
      .pop_i       (done_hs),
      .pop_data_o  (fifo_head)
   );

   always_comb begin
      state_d         = state_q;
      num_d           = num_q;
      delay_d         = delay_q;
      started_d       = started_q + CNT_W'(start_hs);
      done_d          = done_q + CNT_W'(done_hs);
      err_d           = err_q | (ap_done & (outstanding == '0));
      last_lat_d      = last_lat_q;
      max_lat_d       = max_lat_q;
      ap_start_d      = 1'b0;
      ap_continue_d   = ap_continue_q;
      armed_d         = armed_q;
      cnt_d           = cnt_q;
      cur_cnt         = '0;
      busy_d          = 1'b0;
      all_done_d      = (state_q == S_FINISH);
      outstanding_nxt = '0;

      if (done_hs) begin
         last_lat_d = lat_sat;
         if (lat_sat > max_lat_q) max_lat_d = lat_sat;
      end

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               num_d     = cfg_num_txn;
               delay_d   = cfg_cont_delay;
               started_d = '0;
               done_d    = '0;
               max_lat_d = '0;
               err_d     = 1'b0;
               state_d   = (cfg_num_txn == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE:  if (started_q == num_q) state_d = S_DRAIN;
         S_DRAIN:  if (done_q == num_q) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // A pending request is never withdrawn; otherwise re-evaluate on post-handshake counts.
      outstanding_nxt = started_d - done_d;
      if (ap_start_q && !ap_ready) begin
         ap_start_d = 1'b1;
      end else begin
         ap_start_d = (state_d == S_ISSUE) && (started_d < num_d) &&
                      (outstanding_nxt < CNT_W'(MAX_OUTSTANDING));
      end
      busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);

      // First done cycle uses the programmed delay directly so delay 0 acks one cycle later.
      if (done_hs || !ap_done) begin
         ap_continue_d = 1'b0;
         armed_d       = 1'b0;
      end else if ((outstanding != '0) && !ap_continue_q) begin
         cur_cnt = armed_q ? cnt_q : delay_q;
         armed_d = 1'b1;
         if (cur_cnt == '0) ap_continue_d = 1'b1;
         else               cnt_d = cur_cnt - DLY_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         num_q         <= '0;
         started_q     <= '0;
         done_q        <= '0;
         delay_q       <= '0;
         cnt_q         <= '0;
         armed_q       <= 1'b0;
         ap_start_q    <= 1'b0;
         ap_continue_q <= 1'b0;
         busy_q        <= 1'b0;
         all_done_q    <= 1'b0;
         err_q         <= 1'b0;
         last_lat_q    <= '0;
         max_lat_q     <= '0;
         cyc_q         <= '0;
      end else begin
         state_q       <= state_d;
         num_q         <= num_d;
         started_q     <= started_d;
         done_q        <= done_d;
         delay_q       <= delay_d;
         cnt_q         <= cnt_d;
         armed_q       <= armed_d;
         ap_start_q    <= ap_start_d;
         ap_continue_q <= ap_continue_d;
         busy_q        <= busy_d;
         all_done_q    <= all_done_d;
         err_q         <= err_d;
         last_lat_q    <= last_lat_d;
         max_lat_q     <= max_lat_d;
         cyc_q         <= cyc_q + TS_W'(1);
      end
   end

   assign ap_start     = ap_start_q;
   assign ap_continue  = ap_continue_q;
   assign busy         = busy_q;
   assign all_done     = all_done_q;
   assign txn_started  = started_q;
   assign txn_done     = done_q;
   assign last_latency = last_lat_q;
   assign max_latency  = max_lat_q;
   assign err_done     = err_q;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: behavioural kernel plus scoreboard of per-transaction
// latencies and per-run totals, directed scenarios followed by randomized runs.
module tb_ap_ctrl_chain_driver;

   localparam int unsigned MAXO    = 2;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned LAT_W   = 4;
   localparam int unsigned LAT_SAT = (1 << LAT_W) - 1;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             cfg_start = 1'b0;
   logic [CNT_W-1:0] cfg_num_txn = '0;
   logic [7:0]       cfg_cont_delay = '0;
   logic             ap_start;
   logic             ap_ready = 1'b0;
   logic             ap_done = 1'b0;
   logic             ap_continue;
   logic             busy;
   logic             all_done;
   logic [CNT_W-1:0] txn_started;
   logic [CNT_W-1:0] txn_done;
   logic [LAT_W-1:0] last_latency;
   logic [LAT_W-1:0] max_latency;
   logic             err_done;

   always #5 clock = ~clock;

   ap_ctrl_chain_driver #(
      .MAX_OUTSTANDING (MAXO),
      .CNT_W           (CNT_W),
      .LAT_W           (LAT_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .cfg_start      (cfg_start),
      .cfg_num_txn    (cfg_num_txn),
      .cfg_cont_delay (cfg_cont_delay),
      .ap_start       (ap_start),
      .ap_ready       (ap_ready),
      .ap_done        (ap_done),
      .ap_continue    (ap_continue),
      .busy           (busy),
      .all_done       (all_done),
      .txn_started    (txn_started),
      .txn_done       (txn_done),
      .last_latency   (last_latency),
      .max_latency    (max_latency),
      .err_done       (err_done)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Kernel knobs and reference state
   int unsigned ready_pct = 100, lat_min = 1, lat_max = 1, cfg_delay_m = 0;
   bit          force_done = 1'b0;
   int unsigned cyc = 0;
   int unsigned job_ts[$];
   int unsigned job_rdy[$];
   int unsigned exp_lat_q[$];
   int unsigned run_num_q[$];
   int unsigned n_start = 0, n_done = 0, run_max = 0, done_cnt = 0;
   int unsigned d_lat, d_exp, m_num;
   bit          cont_seen = 1'b0, dh_flag = 1'b0, wait_start = 1'b0, all_done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Kernel model: accepts starts, completes in order after a random latency, holds done until acked.
   always @(negedge clock) begin
      cyc++;
      if (!reset_n) begin
         job_ts.delete();
         job_rdy.delete();
         ap_ready   = 1'b0;
         ap_done    = 1'b0;
         done_cnt   = 0;
         cont_seen  = 1'b0;
         dh_flag    = 1'b0;
         wait_start = 1'b0;
      end else begin
         if (ap_continue) begin
            check("continue_only_with_done", ap_done, 1);
            if (!cont_seen) begin
               check("continue_delay", done_cnt, cfg_delay_m + 1);
               cont_seen = 1'b1;
            end
         end
         if (wait_start) check("start_held_until_ready", ap_start, 1);
         if (ap_start) check("outstanding_below_max", (n_start - n_done) < MAXO, 1);

         ap_ready = ($urandom_range(99) < ready_pct);
         ap_done  = force_done || (job_rdy.size() != 0 && job_rdy[0] <= cyc);
         if (ap_done && job_rdy.size() != 0) done_cnt++;
         wait_start = ap_start && !ap_ready;

         dh_flag = ap_done && ap_continue && (job_ts.size() != 0);
         if (dh_flag) begin
            d_lat = cyc - job_ts.pop_front();
            void'(job_rdy.pop_front());
            d_exp = (d_lat > LAT_SAT) ? LAT_SAT : d_lat;
            exp_lat_q.push_back(d_exp);
            if (d_exp > run_max) run_max = d_exp;
            n_done++;
            done_cnt  = 0;
            cont_seen = 1'b0;
         end
         if (ap_start && ap_ready) begin
            job_ts.push_back(cyc);
            job_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
            n_start++;
         end
      end
   end

   // Monitor: compares latency after each completion and run totals on each all_done.
   always @(posedge clock) begin
      #1;
      if (reset_n) begin
         if (dh_flag) begin
            if (exp_lat_q.size() == 0) check("latency_queue_nonempty", 0, 1);
            else check("last_latency", last_latency, exp_lat_q.pop_front());
            check("txn_done_count", txn_done, n_done);
         end
         if (all_done) begin
            check("all_done_single_pulse", all_done_prev, 0);
            if (run_num_q.size() == 0) begin
               check("all_done_expected", 0, 1);
            end else begin
               m_num = run_num_q.pop_front();
               check("run_txn_started", txn_started, m_num);
               check("run_txn_done", txn_done, m_num);
               check("run_max_latency", max_latency, run_max);
               check("run_busy_low", busy, 0);
            end
         end
         all_done_prev = all_done;
      end else begin
         all_done_prev = 1'b0;
      end
   end

   task automatic run(input int unsigned num, input int unsigned dly, input int unsigned rp,
                      input int unsigned lmin, input int unsigned lmax);
      @(posedge clock); #2;
      ready_pct   = rp;
      lat_min     = lmin;
      lat_max     = lmax;
      cfg_delay_m = dly;
      run_max     = 0;
      n_start     = 0;
      n_done      = 0;
      run_num_q.push_back(num);
      cfg_start      = 1'b1;
      cfg_num_txn    = CNT_W'(num);
      cfg_cont_delay = 8'(dly);
      @(posedge clock); #2;
      cfg_start = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned k = 0;
      while (run_num_q.size() != 0 && k < budget) begin
         @(posedge clock);
         k++;
      end
      #2;
      if (run_num_q.size() != 0) begin
         check("run_timeout", run_num_q.size(), 0);
         run_num_q.delete();
      end
   endtask

   initial begin
      int unsigned k;
      #12;
      check("reset_outputs", {ap_start, ap_continue, busy, all_done, txn_started, txn_done,
                              last_latency, max_latency, err_done}, 0);
      @(posedge clock); #2;
      reset_n = 1'b1;

      // Single transaction, immediate ack
      run(1, 0, 100, 5, 5);
      wait_idle(200);

      // Pipelined run limited by the outstanding cap
      run(4, 0, 100, 10, 10);
      wait_idle(300);

      // Long continue back-pressure
      run(3, 7, 100, 2, 4);
      wait_idle(300);

      // Zero-length run: all_done two cycles after cfg_start, no starts
      run(0, 0, 100, 1, 1);
      check("num0_no_all_done_yet", all_done, 0);
      @(posedge clock); #2;
      check("num0_all_done", all_done, 1);
      check("num0_run_retired", run_num_q.size(), 0);
      check("num0_no_start", n_start, 0);
      @(posedge clock); #2;
      check("num0_all_done_cleared", all_done, 0);

      // cfg_start while busy is ignored (different num and delay must not be latched)
      run(3, 2, 100, 3, 6);
      check("busy_during_run", busy, 1);
      cfg_start = 1'b1; cfg_num_txn = CNT_W'(9); cfg_cont_delay = 8'd9;
      @(posedge clock); #2;
      cfg_start = 1'b0;
      wait_idle(300);

      // ap_done with nothing outstanding
      force_done = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      check("err_done_set", err_done, 1);
      check("err_no_continue", ap_continue, 0);
      force_done = 1'b0;
      @(posedge clock); #2;
      check("err_done_sticky", err_done, 1);
      run(1, 0, 100, 2, 2);
      check("err_done_cleared", err_done, 0);
      wait_idle(200);

      // Reset with two transactions in flight
      run(6, 1, 100, 10, 12);
      k = 0;
      while ((n_start - n_done) < 2 && k < 200) begin
         @(posedge clock);
         k++;
      end
      check("two_outstanding_reached", (n_start - n_done) >= 2, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {ap_start, ap_continue, busy, all_done, txn_started, txn_done,
                                     last_latency, max_latency, err_done}, 0);
      run_num_q.delete();
      exp_lat_q.delete();
      repeat (2) @(posedge clock);
      #2;
      exp_lat_q.delete();
      reset_n = 1'b1;
      run(2, 0, 100, 3, 3);
      wait_idle(200);

      // Randomized runs
      for (int r = 0; r < 10; r++) begin
         run($urandom_range(8, 1), $urandom_range(9, 0), $urandom_range(100, 30), 1,
             $urandom_range(14, 1));
         wait_idle(3000);
      end

      repeat (5) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
